ht_res_arb: RTL and testbench

HT_RES_ARB -- requirements
Module: ht_res_arb

---
 rtl/ht_res_arb.sv | 133 +++++++++++++
 tb/tb_ht_res_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ht_res_arb.sv
// ht_res_arb -- round-robin merge of N_CH hash-table result channels into
// a single registered output stream.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   in_key/in_value                 flattened per-channel key/value (channel i = slice i)
//   in_cmd/in_res                   per-channel command echo / result code
//   in_valid/in_ready               per-channel handshake (at most one ready per cycle)
//   o_key/o_value/o_cmd/o_res       merged result (one output register)
//   o_chan                          source channel of the merged result
//   o_valid/o_ready                 merged handshake
//   stat_cnt                        per-channel saturating 16-bit transfer count,
//                                   present only when HT_RES_ARB_STAT_EN is defined
//
// The arbiter uses a rotating pointer: the search begins at rr_ptr and wraps,
// and after each accepted transfer rr_ptr moves one past the winner. That bounds
// the wait of any continuously valid channel to N_CH transfers.

package hash_table;
  parameter int KEY_WIDTH   = 16;
  parameter int VALUE_WIDTH = 32;
  typedef enum logic [1:0] {CMD_SEARCH, CMD_INSERT, CMD_DELETE, CMD_NOP} ht_cmd_t;
  typedef enum logic [1:0] {RES_OK, RES_MISS, RES_FULL, RES_ERR} ht_res_t;
endpackage

// Per-channel saturating transfer counter.
module ht_res_arb_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst)                       cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

module ht_res_arb
  import hash_table::*;
#(
  parameter int N_CH        = 4,
  parameter int KEY_WIDTH   = hash_table::KEY_WIDTH,
  parameter int VALUE_WIDTH = hash_table::VALUE_WIDTH,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH*KEY_WIDTH-1:0]   in_key,
  input  logic [N_CH*VALUE_WIDTH-1:0] in_value,
  input  ht_cmd_t [N_CH-1:0]          in_cmd,
  input  ht_res_t [N_CH-1:0]          in_res,
  input  logic [N_CH-1:0]             in_valid,
  output logic [N_CH-1:0]             in_ready,
  output logic [KEY_WIDTH-1:0]        o_key,
  output logic [VALUE_WIDTH-1:0]      o_value,
  output ht_cmd_t                     o_cmd,
  output ht_res_t                     o_res,
  output logic [CW-1:0]               o_chan,
  output logic                        o_valid,
  input  logic                        o_ready
`ifdef HT_RES_ARB_STAT_EN
  ,
  output logic [N_CH*16-1:0]          stat_cnt
`endif
);

  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   gidx;
  logic [N_CH-1:0] grant;
  logic            any;
  logic            load_en;

  // Output register can take new data when empty or being drained this cycle.
  assign load_en = !o_valid || o_ready;

  // Rotating first-valid search starting at rr_ptr.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any && in_valid[idx]) begin
        any        = 1'b1;
        gidx       = CW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Held low during reset so nothing is consumed while the output is cleared.
  assign in_ready = rst ? '0 : (grant & {N_CH{load_en}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      rr_ptr  <= '0;
      o_key   <= '0;
      o_value <= '0;
      o_cmd   <= ht_cmd_t'(2'b00);
      o_res   <= ht_res_t'(2'b00);
      o_chan  <= '0;
    end else if (load_en) begin
      o_valid <= any;
      if (any) begin
        o_key   <= in_key[gidx*KEY_WIDTH +: KEY_WIDTH];
        o_value <= in_value[gidx*VALUE_WIDTH +: VALUE_WIDTH];
        o_cmd   <= in_cmd[gidx];
        o_res   <= in_res[gidx];
        o_chan  <= gidx;
        if (int'(gidx) == N_CH - 1) rr_ptr <= '0;
        else                        rr_ptr <= gidx + 1'b1;
      end
    end
  end

`ifdef HT_RES_ARB_STAT_EN
  logic [N_CH-1:0] xfer;
  assign xfer = in_valid & in_ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_stat
    ht_res_arb_stat u_stat (
      .clk (clk),
      .rst (rst),
      .inc (xfer[i]),
      .cnt (stat_cnt[i*16 +: 16])
    );
  end
`endif

endmodule

// File: tb/tb_ht_res_arb.sv
// Bench for ht_res_arb (N_CH=4): directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the arbiter. The model
// keeps the expected output contents and the round-robin start channel as
// plain integers and applies the arbitration rules once per clock edge.
module tb_ht_res_arb;
  localparam int N  = 4;
  localparam int KW = hash_table::KEY_WIDTH;
  localparam int VW = hash_table::VALUE_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*KW-1:0] in_key = '0;
  logic [N*VW-1:0] in_value = '0;
  hash_table::ht_cmd_t [N-1:0] in_cmd;
  hash_table::ht_res_t [N-1:0] in_res;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic [KW-1:0] o_key;
  logic [VW-1:0] o_value;
  hash_table::ht_cmd_t o_cmd;
  hash_table::ht_res_t o_res;
  logic [1:0] o_chan;
  logic o_valid;
  logic o_ready = 1'b0;
`ifdef HT_RES_ARB_STAT_EN
  logic [N*16-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  ht_res_arb #(.N_CH(N)) dut (
    .clk(clk), .rst(rst), .in_key(in_key), .in_value(in_value),
    .in_cmd(in_cmd), .in_res(in_res), .in_valid(in_valid), .in_ready(in_ready),
    .o_key(o_key), .o_value(o_value), .o_cmd(o_cmd), .o_res(o_res),
    .o_chan(o_chan), .o_valid(o_valid), .o_ready(o_ready)
`ifdef HT_RES_ARB_STAT_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  int ncmp = 0, nfail = 0;

  // model state
  bit           m_ov;
  logic [KW-1:0] m_key;
  logic [VW-1:0] m_val;
  logic [1:0]   m_cmd, m_res;
  int           m_chan, m_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic model_clear();
    m_ov = 0; m_key = '0; m_val = '0; m_cmd = '0; m_res = '0; m_chan = 0; m_rr = 0;
  endtask

  // One clock: check ready, advance model across the edge, check outputs.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    int g; bit le;
    #1;
    le = !m_ov || o_ready;
    g  = pick();
    chk("in_ready", 64'(in_ready), (le && g >= 0) ? 64'(1 << g) : 64'd0);
    @(posedge clk);
    if (le) begin
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_key  = in_key[g*KW +: KW];
        m_val  = in_value[g*VW +: VW];
        m_cmd  = in_cmd[g];
        m_res  = in_res[g];
        m_chan = g;
        m_rr   = (g + 1) % N;
      end
    end
    #1;
    chk("o_valid", 64'(o_valid), 64'(m_ov));
    if (m_ov) begin
      chk("o_key",   64'(o_key),   64'(m_key));
      chk("o_value", 64'(o_value), 64'(m_val));
      chk("o_cmd",   64'(o_cmd),   64'(m_cmd));
      chk("o_res",   64'(o_res),   64'(m_res));
      chk("o_chan",  64'(o_chan),  64'(m_chan));
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      in_key[i*KW +: KW]   = KW'($urandom);
      in_value[i*VW +: VW] = VW'($urandom);
      in_cmd[i] = hash_table::ht_cmd_t'($urandom_range(0, 3));
      in_res[i] = hash_table::ht_res_t'($urandom_range(0, 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_o_valid",  64'(o_valid),  64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_o_key",    64'(o_key),    64'd0);
    chk("rst_o_value",  64'(o_value),  64'd0);
    chk("rst_o_chan",   64'(o_chan),   64'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int seq [8];

  initial begin
    for (int i = 0; i < N; i++) begin
      in_cmd[i] = hash_table::CMD_SEARCH;
      in_res[i] = hash_table::RES_OK;
    end
    model_clear();
    do_reset();

    // All channels valid, output always drained: strict rotation 0..3.
    rand_inputs();
    in_valid = 4'b1111; o_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      seq[c] = int'(o_chan);
      chk("rot_valid", 64'(o_valid), 64'd1);
      chk("rot_chan", 64'(seq[c]), 64'(c % 4));
    end

    // Single channel 2 with a known key; next grant must start at channel 3.
    in_valid = '0; o_ready = 1'b1;
    cycle(); cycle();
    do_reset();
    in_key[2*KW +: KW] = 16'h1234;
    in_valid = 4'b0100;
    cycle();
    chk("ch2_key",  64'(o_key),  64'h1234);
    chk("ch2_chan", 64'(o_chan), 64'd2);
    in_valid = 4'b1111;
    #1 chk("rr_after_ch2", 64'(in_ready), 64'b1000);
    cycle();

    // Output full and stalled: nothing moves for 5 cycles.
    do_reset();
    in_key[3*KW +: KW] = 16'hAAAA;
    in_valid = 4'b1000; o_ready = 1'b0;
    cycle();
    in_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stall_key",   64'(o_key),    64'hAAAA);
      chk("stall_ready", 64'(in_ready), 64'd0);
    end
    o_ready = 1'b1;
    #1 chk("unstall_grant", 64'(in_ready), 64'b0001);
    cycle();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      in_valid = N'($urandom);
      o_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset mid-stream with a held output; restart from channel 0.
    rand_inputs();
    in_valid = 4'b1111; o_ready = 1'b0;
    cycle(); cycle();
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    do_reset();
    in_valid = 4'b0110; o_ready = 1'b1;
    #1 chk("post_rst_grant", 64'(in_ready), 64'b0010);
    cycle();
    chk("post_rst_chan", 64'(o_chan), 64'd1);

    for (int c = 0; c < 1000; c++) begin
      rand_inputs();
      in_valid = N'($urandom);
      o_ready  = ($urandom_range(0, 1) != 0);
      cycle();
    end

`ifdef HT_RES_ARB_STAT_EN
    do_reset();
    in_valid = 4'b0010; o_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_ch1", 64'(stat_cnt[16 +: 16]), 64'hFFFF);
    chk("stat_ch0", 64'(stat_cnt[0 +: 16]),  64'd0);
    chk("stat_ch2", 64'(stat_cnt[32 +: 16]), 64'd0);
    chk("stat_ch3", 64'(stat_cnt[48 +: 16]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
